// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative cache.
// The width helpers keep the top and the PLRU sub-module in step.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        REFILL
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_WORDS  = 8;
    localparam int DEF_SETS   = 16;

    typedef logic [DEF_WORDS*DEF_DATA_W-1:0] line_t;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line * 4);
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_line, input int num_sets);
        return addr_w - idx_w(num_sets) - off_w(words_per_line);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set pseudo-LRU replacement state: 1 bit per set for 2 ways, 3-bit tree for 4 ways.
// Latency: victim_way is combinational from index; updates land on the next clk edge.
// Backpressure: none; update is applied whenever asserted.
module cache_plru
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int WAYS     = 2,
    localparam int IDX_W   = idx_w(NUM_SETS),
    localparam int WAY_W   = way_w(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [WAY_W-1:0] hit_way,
    input  logic             update,
    output logic [WAY_W-1:0] victim_way
);

    if (WAYS == 4) begin : g_tree
        // t0 picks the half holding the victim, t1/t2 the way within each half.
        logic [NUM_SETS-1:0] t0;
        logic [NUM_SETS-1:0] t1;
        logic [NUM_SETS-1:0] t2;

        always_ff @(posedge clk) begin
            if (rst) begin
                t0 <= '0;
                t1 <= '0;
                t2 <= '0;
            end else if (update) begin
                t0[index] <= ~hit_way[1];
                if (hit_way[1]) begin
                    t2[index] <= ~hit_way[0];
                end else begin
                    t1[index] <= ~hit_way[0];
                end
            end
        end

        assign victim_way = t0[index] ? {1'b1, t2[index]} : {1'b0, t1[index]};
    end else if (WAYS == 2) begin : g_bit
        logic [NUM_SETS-1:0] lru;

        always_ff @(posedge clk) begin
            if (rst) begin
                lru <= '0;
            end else if (update) begin
                lru[index] <= ~hit_way[0];
            end
        end

        assign victim_way = lru[index];
    end else begin : g_none
        logic unused_plru;
        assign unused_plru = ^{clk, rst, index, hit_way, update};
        assign victim_way  = '0;
    end

endmodule

// File: rtl/cache_sa_ctrl.sv
// Set-associative write-back/write-allocate cache with integrated miss FSM; CACHE_STATS_EN adds counters.
// Latency: hit completes (cpu_done) two cycles after the request is presented; misses add memory round trips.
// Backpressure: cpu_ready low while busy; mem_req held until mem_ack, stalling indefinitely without it.
module cache_sa_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int NUM_SETS       = 16,
    parameter int WAYS           = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_req,
    input  logic                             cpu_we,
    input  logic [ADDR_W-1:0]                cpu_addr,
    input  logic [DATA_W-1:0]                cpu_wdata,
    output logic                             cpu_ready,
    output logic                             cpu_done,
    output logic [DATA_W-1:0]                cpu_rdata,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [WORDS_PER_LINE*DATA_W-1:0] mem_wdata,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] mem_rdata,
    input  logic                             mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                      stat_hits,
    output logic [31:0]                      stat_misses,
    output logic [31:0]                      stat_wbacks
`endif
);

    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w(NUM_SETS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS_PER_LINE, NUM_SETS);
    localparam int WORD_W = OFF_W - 2;
    localparam int WAY_W  = way_w(WAYS);
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;

    state_t              state;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WORD_W-1:0]   req_word;
    logic                req_we;
    logic [DATA_W-1:0]   req_wdata;
    logic [WAY_W-1:0]    victim_q;

    logic [LINE_W-1:0]   data_arr [WAYS][NUM_SETS];
    logic [TAG_W-1:0]    tag_arr  [WAYS][NUM_SETS];
    logic [NUM_SETS-1:0] valid    [WAYS];
    logic [NUM_SETS-1:0] dirty    [WAYS];

    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                have_inv;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_victim;
    logic [WAY_W-1:0]    victim;
    logic [LINE_W-1:0]   hit_line;
    logic [DATA_W-1:0]   hit_word;
    logic                victim_dirty;
    logic                plru_update;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][req_idx] && tag_arr[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        have_inv = 1'b0;
        inv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][req_idx]) begin
                have_inv = 1'b1;
                inv_way  = WAY_W'(w);
            end
        end
    end

    assign victim       = have_inv ? inv_way : plru_victim;
    assign victim_dirty = valid[victim][req_idx] && dirty[victim][req_idx];
    assign hit_line     = data_arr[hit_way][req_idx];
    assign hit_word     = hit_line[req_word*DATA_W +: DATA_W];
    assign plru_update  = (state == COMPARE) && hit;

    cache_plru #(
        .NUM_SETS (NUM_SETS),
        .WAYS     (WAYS)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .index      (req_idx),
        .hit_way    (hit_way),
        .update     (plru_update),
        .victim_way (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            victim_q  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
                        req_idx   <= cpu_addr[OFF_W +: IDX_W];
                        req_word  <= cpu_addr[2 +: WORD_W];
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        cpu_ready <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_we) begin
                            dirty[hit_way][req_idx] <= 1'b1;
                        end else begin
                            cpu_rdata <= hit_word;
                        end
                        cpu_done  <= 1'b1;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        victim_q <= victim;
                        mem_req  <= 1'b1;
                        if (victim_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[victim][req_idx], req_idx, {OFF_W{1'b0}}};
                            mem_wdata <= data_arr[victim][req_idx];
                            state     <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state    <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        dirty[victim_q][req_idx] <= 1'b0;
                        mem_req                  <= 1'b0;
                        state                    <= REFILL;
                    end
                end
                REFILL: begin
                    // Arriving from WRITEBACK, mem_req is low for one cycle before the fetch.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end else if (mem_ack) begin
                        mem_req                  <= 1'b0;
                        valid[victim_q][req_idx] <= 1'b1;
                        dirty[victim_q][req_idx] <= 1'b0;
                        state                    <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == COMPARE && hit && req_we) begin
                data_arr[hit_way][req_idx][req_word*DATA_W +: DATA_W] <= req_wdata;
            end
            if (state == REFILL && mem_req && mem_ack) begin
                data_arr[victim_q][req_idx] <= mem_rdata;
                tag_arr[victim_q][req_idx]  <= req_tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // retry marks the COMPARE pass that follows a refill so it is not counted as a hit.
    logic retry;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
            retry       <= 1'b0;
        end else begin
            if (state == REFILL && mem_req && mem_ack) begin
                retry <= 1'b1;
            end
            if (state == COMPARE) begin
                if (hit) begin
                    retry <= 1'b0;
                    if (!retry && stat_hits != '1) begin
                        stat_hits <= stat_hits + 32'd1;
                    end
                end else if (stat_misses != '1) begin
                    stat_misses <= stat_misses + 32'd1;
                end
            end
            if (state == WRITEBACK && mem_ack && stat_wbacks != '1) begin
                stat_wbacks <= stat_wbacks + 32'd1;
            end
        end
    end
`endif

endmodule
